movegen_sequencer: RTL
======================

Name: movegen_sequencer

Overview:
- Controller that sequences one pseudolegal move-generation pass.
- Accepts a 64-square serial position plus side-to-move, castling and ep metadata from the host, and forwards it to the move-generation board.
- After load and a settle delay, pulses the board's start input, then forwards and counts the 20-bit UCI move stream until end-of-list.
- Reports completion, move count, and length/timeout errors.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between the last forwarded square and board_start (1..15).
- TIMEOUT_CYCLES, 1024, maximum COLLECT cycles without a terminating eop before abort (2..65535).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous and active-high.
- host_pos_valid  in  1  square nibble valid.
- host_pos_data  in  4  square nibble {colour, piece[2:0]}.
- host_pos_sop  in  1  first square (a8-order serial start).
- host_pos_eop  in  1  last square.
- host_wtp  in  1  white to play; sampled on the accepted sop beat.
- host_castle  in  4  KQkq rights; sampled on the accepted sop beat.
- host_ep  in  3  ep file; sampled on the accepted sop beat.
- host_abort  in  1  abandon the current pass.
- host_pos_ready  out  1  beats accepted when valid&ready.
- board_pos_valid, board_pos_sop, board_pos_eop  out  1 each  forwarded square framing.
- board_pos_data  out  4  forwarded nibble.
- board_wtp, board_castle, board_ep  out  1/4/3  held metadata.
- board_start  out  1  single-cycle generation start.
- board_uci_valid, board_uci_sop, board_uci_eop  in  1 each  board move stream framing.
- board_uci_data  in  20  {promote, piece, from_rf, takes, to_rf}.
- mv_valid  out  1  forwarded move valid.
- mv_data  out  20  forwarded move.
- mv_last  out  1  last move of the pass.
- gen_done  out  1  one-cycle pulse at end of pass.
- gen_count  out  8  moves in the last pass, saturating at 255.
- err_len  out  1  sticky bad-length error.
- err_timeout  out  1  sticky timeout error.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE; every output 0 except host_pos_ready=1; square counter, settle counter, timeout counter and gen_count all 0.
- States: IDLE, LOAD, SETTLE, START, COLLECT.
- host_pos_ready=1 in IDLE and LOAD only.
- IDLE:
  - Accepted beat without sop is dropped.
  - Accepted sop beat: capture wtp/castle/ep into board_*; clear err_len, err_timeout and gen_count; square count=1; go to LOAD.
  - If the sop beat also has eop: count is 1, treated as a length error (see below).
- Forwarding: every accepted beat in IDLE(sop)/LOAD is registered onto board_pos_* one cycle later. Latency is exactly 1; there is no backpressure from the board.
- LOAD:
  - Each accepted beat increments the 7-bit count.
  - sop mid-LOAD: restart count at 1, recapture metadata, forward the beat.
  - eop with count==64 (including this beat): go to SETTLE.
  - eop with count!=64, or a 65th beat without eop: set err_len; the beat is still forwarded; go to IDLE; no board_start.
- SETTLE: wait SETTLE_CYCLES cycles, then go to START.
- START: board_start=1 for exactly one cycle; clear the timeout counter; go to COLLECT.
- COLLECT:
  - Each board_uci_valid beat is registered to mv_valid/mv_data one cycle later; mv_last=board_uci_eop.
  - gen_count increments per valid beat, saturating at 255.
  - uci_eop is honoured only with uci_valid. On the valid&eop beat: go to IDLE; gen_done pulses in the same cycle mv_last is presented.
  - board_uci_sop is forwarded nowhere. sop outside COLLECT is ignored, and so are uci beats in any other state.
  - Timeout counter increments every COLLECT cycle. Reaching TIMEOUT_CYCLES without eop: set err_timeout, pulse gen_done with gen_count as accumulated, go to IDLE. A valid&eop in that same cycle takes priority: no error.
- host_abort (any state, synchronous): go to IDLE next cycle; no gen_done; errors unchanged; board_start suppressed if the current state is START; in-flight registered forward beats still complete.
- Simultaneous host_abort and an accepted sop in IDLE: abort wins and the beat is dropped.
- rst asserted mid-pass: immediate return to reset values; partial output is lost.

Test Plan:
- Load 64 squares (sop on 1, eop on 64), wtp=1, castle=4'hF, ep=3'd4 -> board_pos_* mirror each beat 1 cycle later; board_start pulses once, exactly SETTLE_CYCLES+1 cycles after the board eop beat; board_wtp=1, board_castle=F, board_ep=4.
- After start, board emits 20 moves, eop on the 20th -> 20 mv_valid beats with 1-cycle latency, mv_last on the 20th, gen_done coincident with it, gen_count=20, no errors.
- eop on beat 63 -> err_len=1, no board_start, return to IDLE. A following 64-beat load clears err_len and proceeds normally.
- Board never asserts eop, TIMEOUT_CYCLES=16 -> err_timeout=1 and gen_done pulse 16 cycles after start, busy=0 next cycle. With 300 moves and eop: gen_count=255.
- host_abort asserted in SETTLE -> no board_start, busy=0 next cycle, gen_done stays 0.
- rst pulsed during COLLECT -> all outputs 0, host_pos_ready=1 immediately (asynchronous), subsequent load works normally.

Source files
------------

// File: rtl/movegen_sequencer.sv
// movegen_sequencer: sequences one pseudolegal move-generation pass.
// Ports:
//   clk, rst                      clock, async active-high reset
//   host_pos_* / host_wtp/castle/ep  serial 64-square position + metadata from host
//   host_abort                    abandon the current pass
//   board_pos_* / board_wtp/castle/ep  forwarded position and held metadata
//   board_start                   one-cycle generation start
//   board_uci_*                   move stream from the board
//   mv_valid/mv_data/mv_last      forwarded move stream
//   gen_done, gen_count           end-of-pass pulse, saturating move count
//   err_len, err_timeout, busy    sticky errors, activity flag
module movegen_sequencer #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_pos_valid,
    input  logic [3:0]  host_pos_data,
    input  logic        host_pos_sop,
    input  logic        host_pos_eop,
    input  logic        host_wtp,
    input  logic [3:0]  host_castle,
    input  logic [2:0]  host_ep,
    input  logic        host_abort,
    output logic        host_pos_ready,
    output logic        board_pos_valid,
    output logic        board_pos_sop,
    output logic        board_pos_eop,
    output logic [3:0]  board_pos_data,
    output logic        board_wtp,
    output logic [3:0]  board_castle,
    output logic [2:0]  board_ep,
    output logic        board_start,
    input  logic        board_uci_valid,
    input  logic        board_uci_sop,
    input  logic        board_uci_eop,
    input  logic [19:0] board_uci_data,
    output logic        mv_valid,
    output logic [19:0] mv_data,
    output logic        mv_last,
    output logic        gen_done,
    output logic [7:0]  gen_count,
    output logic        err_len,
    output logic        err_timeout,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, START, COLLECT} state_t;

    // The first SETTLE cycle is the one where the last square sits on the
    // board bus, so SETTLE lasts SETTLE_CYCLES+1 cycles.
    localparam logic [3:0]  SETTLE_LAST  = 4'(SETTLE_CYCLES);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic [6:0]  sq_cnt, sq_nx;
    logic [3:0]  settle_cnt;
    logic [15:0] to_cnt;
    logic        accept, take_sop, fwd, len_bad, mv_fwd, uci_end, to_fire;
    logic        done_q, err_to_q;

    assign host_pos_ready = (state == IDLE) || (state == LOAD);
    assign busy           = state != IDLE;
    assign accept         = host_pos_valid && host_pos_ready && !host_abort;
    assign take_sop       = accept && host_pos_sop;
    assign fwd            = accept && (host_pos_sop || state == LOAD);
    assign sq_nx          = host_pos_sop ? 7'd1 : sq_cnt + 7'd1;
    // eop must land exactly on square 64; a 65th beat without eop is also bad.
    assign len_bad        = fwd && (host_pos_eop ? sq_nx != 7'd64 : sq_nx == 7'd65);
    assign mv_fwd         = (state == COLLECT) && board_uci_valid && !host_abort;
    assign uci_end        = mv_fwd && board_uci_eop;
    // A terminating move in the last allowed cycle beats the timeout.
    assign to_fire        = (state == COLLECT) && !host_abort && to_cnt == TIMEOUT_LAST
                            && !(board_uci_valid && board_uci_eop);
    assign board_start    = (state == START) && !host_abort;
    assign gen_done       = done_q || to_fire;
    assign err_timeout    = err_to_q || to_fire;

    always_comb begin
        state_nx = state;
        if (host_abort)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = (fwd && !len_bad) ? LOAD : IDLE;
                LOAD:    state_nx = len_bad ? IDLE : (fwd && host_pos_eop) ? SETTLE : LOAD;
                SETTLE:  state_nx = (settle_cnt == SETTLE_LAST) ? START : SETTLE;
                START:   state_nx = COLLECT;
                COLLECT: state_nx = (uci_end || to_fire) ? IDLE : COLLECT;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            sq_cnt          <= '0;
            settle_cnt      <= '0;
            to_cnt          <= '0;
            board_pos_valid <= 1'b0;
            board_pos_sop   <= 1'b0;
            board_pos_eop   <= 1'b0;
            board_pos_data  <= '0;
            board_wtp       <= 1'b0;
            board_castle    <= '0;
            board_ep        <= '0;
            mv_valid        <= 1'b0;
            mv_data         <= '0;
            mv_last         <= 1'b0;
            done_q          <= 1'b0;
            gen_count       <= '0;
            err_len         <= 1'b0;
            err_to_q        <= 1'b0;
        end else begin
            state           <= state_nx;
            settle_cnt      <= (state == SETTLE) ? settle_cnt + 4'd1 : '0;
            to_cnt          <= (state == COLLECT) ? to_cnt + 16'd1 : '0;
            board_pos_valid <= fwd;
            board_pos_sop   <= fwd && host_pos_sop;
            board_pos_eop   <= fwd && host_pos_eop;
            mv_valid        <= mv_fwd;
            mv_last         <= uci_end;
            done_q          <= uci_end;
            if (fwd) begin
                sq_cnt         <= sq_nx;
                board_pos_data <= host_pos_data;
            end
            if (take_sop) begin
                board_wtp    <= host_wtp;
                board_castle <= host_castle;
                board_ep     <= host_ep;
            end
            if (take_sop && state == IDLE) begin
                err_len   <= 1'b0;
                err_to_q  <= 1'b0;
                gen_count <= '0;
            end
            if (len_bad)
                err_len <= 1'b1;
            if (to_fire)
                err_to_q <= 1'b1;
            if (mv_fwd)
                mv_data <= board_uci_data;
            if (mv_fwd && gen_count != 8'hFF)
                gen_count <= gen_count + 8'd1;
        end
    end
endmodule
